// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_CNT_W = 3;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;
  localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    WB_ARB_IDLE  = 2'd0,
    WB_ARB_PEND  = 2'd1,
    WB_ARB_FORCE = 2'd2
  } wb_arb_state_e;

  // Writes to x0 are architecturally void and never reach the regfile.
  function automatic logic is_live(input logic we, input logic [REG_ADDR_W-1:0] addr);
    return we && (addr != ZERO_REG);
  endfunction

endpackage

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback has priority, MCU results wait in a one-entry buffer.
// Optional macro WB_ARB_BYPASS_EN: an MCU result accepted while the pipeline is quiet is written directly.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_waddr_i,
  input  logic [REG_DATA_W-1:0] wb_wdata_i,
  input  logic                  mcu_valid_i,
  output logic                  mcu_ready_o,
  input  logic [REG_ADDR_W-1:0] mcu_waddr_i,
  input  logic [REG_DATA_W-1:0] mcu_wdata_i,
  output logic                  stall_o,
  output logic                  reg_we_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic [REG_DATA_W-1:0] reg_wdata_o,
  output wb_arb_state_e         dbg_state_o
);

  // Handshake: an MCU result transfers on a rising edge where mcu_valid_i && mcu_ready_o;
  // the MCU must hold valid/addr/data stable until that edge, ready never depends on valid.

  wb_arb_state_e           state_q, state_d;
  logic [REG_ADDR_W-1:0]   buf_addr_q;
  logic [REG_DATA_W-1:0]   buf_data_q;
  logic [CNT_W-1:0]        cnt_q;

  logic                    wb_live, mcu_take, same_addr;
  logic                    sel_we, buf_load, cnt_inc;
  logic [REG_ADDR_W-1:0]   sel_addr;
  logic [REG_DATA_W-1:0]   sel_data;

  assign wb_live     = is_live(wb_we_i, wb_waddr_i);
  assign mcu_ready_o = (state_q == WB_ARB_IDLE);
  assign stall_o     = (state_q == WB_ARB_FORCE);
  assign mcu_take    = mcu_valid_i && mcu_ready_o && (mcu_waddr_i != ZERO_REG);
  assign same_addr   = (wb_waddr_i == buf_addr_q);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= WB_ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_ARB_IDLE:  if (buf_load) state_d = WB_ARB_PEND;
      WB_ARB_PEND: begin
        if (!wb_live || same_addr)               state_d = WB_ARB_IDLE;
        else if (int'(cnt_q) + 1 >= STARVE_LIMIT) state_d = WB_ARB_FORCE;
      end
      WB_ARB_FORCE: state_d = WB_ARB_IDLE;
      default:      state_d = WB_ARB_IDLE;
    endcase
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = ZERO_REG;
    sel_data = ZERO_WORD;
    buf_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      WB_ARB_IDLE: begin
        if (wb_live) begin
          sel_we   = 1'b1;
          sel_addr = wb_waddr_i;
          sel_data = wb_wdata_i;
        end
`ifdef WB_ARB_BYPASS_EN
        if (mcu_take && !wb_live) begin
          sel_we   = 1'b1;
          sel_addr = mcu_waddr_i;
          sel_data = mcu_wdata_i;
        end
        buf_load = mcu_take && wb_live;
`else
        buf_load = mcu_take;
`endif
      end
      WB_ARB_PEND: begin
        sel_we = 1'b1;
        if (wb_live) begin
          sel_addr = wb_waddr_i;
          sel_data = wb_wdata_i;
          cnt_inc  = !same_addr;
        end else begin
          sel_addr = buf_addr_q;
          sel_data = buf_data_q;
        end
      end
      WB_ARB_FORCE: begin
        // A held younger write to the same register supersedes the buffered result.
        if (!(wb_live && same_addr)) begin
          sel_we   = 1'b1;
          sel_addr = buf_addr_q;
          sel_data = buf_data_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_we_o    <= 1'b0;
      reg_waddr_o <= ZERO_REG;
      reg_wdata_o <= ZERO_WORD;
      buf_addr_q  <= ZERO_REG;
      buf_data_q  <= ZERO_WORD;
      cnt_q       <= '0;
    end else begin
      reg_we_o    <= sel_we;
      reg_waddr_o <= sel_addr;
      reg_wdata_o <= sel_data;
      if (buf_load) begin
        buf_addr_q <= mcu_waddr_i;
        buf_data_q <= mcu_wdata_i;
      end
      if (state_q != WB_ARB_PEND || state_d != WB_ARB_PEND) cnt_q <= '0;
      else if (cnt_inc && cnt_q != {CNT_W{1'b1}})         cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int LIMIT = 4;
  localparam int RAND_CYCLES = 3000;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  wb_we_i = 1'b0;
  logic [REG_ADDR_W-1:0] wb_waddr_i = '0;
  logic [REG_DATA_W-1:0] wb_wdata_i = '0;
  logic                  mcu_valid_i = 1'b0;
  logic                  mcu_ready_o;
  logic [REG_ADDR_W-1:0] mcu_waddr_i = '0;
  logic [REG_DATA_W-1:0] mcu_wdata_i = '0;
  logic                  stall_o;
  logic                  reg_we_o;
  logic [REG_ADDR_W-1:0] reg_waddr_o;
  logic [REG_DATA_W-1:0] reg_wdata_o;
  wb_arb_state_e         dbg_state_o;

  int checks = 0;
  int failures = 0;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .mcu_valid_i(mcu_valid_i), .mcu_ready_o(mcu_ready_o),
    .mcu_waddr_i(mcu_waddr_i), .mcu_wdata_i(mcu_wdata_i),
    .stall_o(stall_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic set_wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    wb_we_i = we; wb_waddr_i = addr; wb_wdata_i = data;
  endtask

  task automatic set_mcu(input logic v, input logic [4:0] addr, input logic [31:0] data);
    mcu_valid_i = v; mcu_waddr_i = addr; mcu_wdata_i = data;
  endtask

  task automatic idle_inputs();
    set_wb(1'b0, 5'd0, 32'd0);
    set_mcu(1'b0, 5'd0, 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    checks++;
    if (reg_we_o !== 1'b0 || reg_waddr_o !== 5'd0 || reg_wdata_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h, want 0/0/0", reg_we_o, reg_waddr_o, reg_wdata_o);
    end
    checks++;
    if (stall_o !== 1'b0 || mcu_ready_o !== 1'b1 || dbg_state_o !== WB_ARB_IDLE) begin
      failures++;
      $display("FAIL reset_state: got stall=%b ready=%b state=%0d, want 0/1/IDLE", stall_o, mcu_ready_o, dbg_state_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_pend();
    // Buffer x5=0x11 by pairing the accept with a live pipeline write.
    set_wb(1'b1, 5'd6, 32'h1);
    set_mcu(1'b1, 5'd5, 32'h11);
    tick();
    idle_inputs();
    checks++;
    if (reg_we_o !== 1'b1 || dbg_state_o !== WB_ARB_PEND) begin
      failures++;
      $display("FAIL mid_pend_setup: got we=%b state=%0d, want 1/PEND", reg_we_o, dbg_state_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (reg_we_o !== 1'b0 || dbg_state_o !== WB_ARB_IDLE) begin
      failures++;
      $display("FAIL async_reset: got we=%b state=%0d, want 0/IDLE", reg_we_o, dbg_state_o);
    end
    #1 rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (reg_we_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_discard: cycle %0d got we=%b addr=%0d, want no write", i, reg_we_o, reg_waddr_o);
      end
    end
  endtask

  task automatic test_mcu_latency();
    checks++;
    if (mcu_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready: got %b want 1", mcu_ready_o);
    end
    set_mcu(1'b1, 5'd5, 32'hAA);
    tick();
    idle_inputs();
`ifdef WB_ARB_BYPASS_EN
    checks++;
    if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd5 || reg_wdata_o !== 32'hAA) begin
      failures++;
      $display("FAIL bypass_t1: got we=%b addr=%0d data=%h, want 1/5/aa", reg_we_o, reg_waddr_o, reg_wdata_o);
    end
    tick();
    checks++;
    if (reg_we_o !== 1'b0) begin
      failures++;
      $display("FAIL bypass_t2: got we=%b want 0", reg_we_o);
    end
`else
    checks++;
    if (reg_we_o !== 1'b0) begin
      failures++;
      $display("FAIL buffered_t1: got we=%b want 0", reg_we_o);
    end
    tick();
    checks++;
    if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd5 || reg_wdata_o !== 32'hAA) begin
      failures++;
      $display("FAIL buffered_t2: got we=%b addr=%0d data=%h, want 1/5/aa", reg_we_o, reg_waddr_o, reg_wdata_o);
    end
    tick();
`endif
  endtask

  task automatic test_same_cycle();
    set_wb(1'b1, 5'd6, 32'h1);
    set_mcu(1'b1, 5'd5, 32'hAA);
    tick();
    idle_inputs();
    checks++;
    if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd6 || reg_wdata_o !== 32'h1) begin
      failures++;
      $display("FAIL same_cycle_pipe: got we=%b addr=%0d data=%h, want 1/6/1", reg_we_o, reg_waddr_o, reg_wdata_o);
    end
    tick();
    checks++;
    if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd5 || reg_wdata_o !== 32'hAA) begin
      failures++;
      $display("FAIL same_cycle_mcu: got we=%b addr=%0d data=%h, want 1/5/aa", reg_we_o, reg_waddr_o, reg_wdata_o);
    end
    tick();
  endtask

  task automatic test_waw_drop();
    set_wb(1'b1, 5'd6, 32'h3);
    set_mcu(1'b1, 5'd5, 32'hAA);
    tick();
    set_mcu(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd5, 32'h22);
    tick();
    idle_inputs();
    checks++;
    if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd5 || reg_wdata_o !== 32'h22) begin
      failures++;
      $display("FAIL waw_young: got we=%b addr=%0d data=%h, want 1/5/22", reg_we_o, reg_waddr_o, reg_wdata_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (reg_we_o !== 1'b0) begin
        failures++;
        $display("FAIL waw_dropped: cycle %0d got we=%b addr=%0d data=%h, want no write", i, reg_we_o, reg_waddr_o, reg_wdata_o);
      end
    end
  endtask

  task automatic test_starvation();
    logic [4:0]  exp_addr [7];
    logic [31:0] exp_data [7];
    exp_addr = '{5'd9, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd10};
    exp_data = '{32'h90, 32'h10, 32'h20, 32'h30, 32'h40, 32'h77, 32'hA0};
    set_wb(1'b1, 5'd9, 32'h90);
    set_mcu(1'b1, 5'd7, 32'h77);
    tick();
    set_mcu(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      set_wb(1'b1, exp_addr[i], exp_data[i]);
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
        failures++;
        $display("FAIL starve_nostall: deferral %0d got stall=%b want 0", i, stall_o);
      end
      tick();
    end
    set_wb(1'b1, 5'd10, 32'hA0);
    #1;
    checks++;
    if (stall_o !== 1'b1 || mcu_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL starve_stall: got stall=%b ready=%b want 1/0", stall_o, mcu_ready_o);
    end
    tick();
    checks++;
    if (stall_o !== 1'b0) begin
      failures++;
      $display("FAIL starve_one_cycle: got stall=%b want 0", stall_o);
    end
    tick();
    idle_inputs();
    // Writes observed: 9,1,2,3,4 already checked below via replay of the sequence order.
    checks++;
    if (reg_we_o !== 1'b1 || reg_waddr_o !== exp_addr[6] || reg_wdata_o !== exp_data[6]) begin
      failures++;
      $display("FAIL starve_held_issue: got we=%b addr=%0d data=%h, want 1/%0d/%h", reg_we_o, reg_waddr_o, reg_wdata_o, exp_addr[6], exp_data[6]);
    end
    tick();
    checks++;
    if (reg_we_o !== 1'b0) begin
      failures++;
      $display("FAIL starve_no_dup: got we=%b addr=%0d, want no write", reg_we_o, reg_waddr_o);
    end
  endtask

  task automatic test_starve_order();
    // Same scenario, checking every write in order including the forced MCU write.
    logic [4:0]  exp_addr [7];
    logic [31:0] exp_data [7];
    exp_addr = '{5'd9, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd10};
    exp_data = '{32'h91, 32'h11, 32'h21, 32'h31, 32'h41, 32'h78, 32'hA1};
    set_wb(1'b1, exp_addr[0], exp_data[0]);
    set_mcu(1'b1, exp_addr[5], exp_data[5]);
    for (int i = 0; i < 7; i++) begin
      if (i >= 1 && i <= 4) set_wb(1'b1, exp_addr[i], exp_data[i]);
      if (i >= 5)           set_wb(1'b1, exp_addr[6], exp_data[6]);
      tick();
      set_mcu(1'b0, 5'd0, 32'd0);
      checks++;
      if (reg_we_o !== 1'b1 || reg_waddr_o !== exp_addr[i] || reg_wdata_o !== exp_data[i]) begin
        failures++;
        $display("FAIL starve_order[%0d]: got we=%b addr=%0d data=%h, want 1/%0d/%h", i, reg_we_o, reg_waddr_o, reg_wdata_o, exp_addr[i], exp_data[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0_write();
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    checks++;
    if (reg_we_o !== 1'b0) begin
      failures++;
      $display("FAIL x0_idle: got we=%b addr=%0d data=%h, want no write", reg_we_o, reg_waddr_o, reg_wdata_o);
    end
    set_wb(1'b1, 5'd9, 32'h9);
    set_mcu(1'b1, 5'd3, 32'h33);
    tick();
    set_mcu(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    idle_inputs();
    checks++;
    if (reg_we_o !== 1'b1 || reg_waddr_o !== 5'd3 || reg_wdata_o !== 32'h33) begin
      failures++;
      $display("FAIL x0_buffer_drain: got we=%b addr=%0d data=%h, want 1/3/33", reg_we_o, reg_waddr_o, reg_wdata_o);
    end
    tick();
  endtask

  // ---------------- randomized traffic vs queue model ----------------
  logic [37:0] exp_q [$];   // {we, addr, data} expected on reg_* after each edge
  logic [36:0] mbuf [$];    // model's pending MCU result {addr, data}
  int          deferred;
  bit          forcing;
  logic [REG_DATA_W-1:0] model_rf [32];
  logic [REG_DATA_W-1:0] dut_rf [32];

  task automatic test_random();
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        live;
    logic        exp_stall, exp_ready;
    int          accepted, mcu_written;
    do_reset();
    idle_inputs();
    exp_q.delete(); mbuf.delete();
    deferred = 0; forcing = 0;
    accepted = 0; mcu_written = 0;
    for (int r = 0; r < 32; r++) begin model_rf[r] = '0; dut_rf[r] = '0; end
    for (int c = 0; c < RAND_CYCLES; c++) begin
      exp_stall = forcing;
      exp_ready = !forcing && (mbuf.size() == 0);
      if (!exp_stall) begin
        if ($urandom_range(0, 9) < 7)
          set_wb(1'b1, 5'($urandom_range(0, 7)), $urandom);
        else
          set_wb(1'b0, 5'($urandom_range(0, 7)), $urandom);
      end
      if (!mcu_valid_i && $urandom_range(0, 9) < 4)
        set_mcu(1'b1, 5'($urandom_range(0, 7)), $urandom);
      #1;
      checks++;
      if (stall_o !== exp_stall || mcu_ready_o !== exp_ready) begin
        failures++;
        $display("FAIL rand_ctrl c=%0d: got stall=%b ready=%b, want %b/%b", c, stall_o, mcu_ready_o, exp_stall, exp_ready);
      end
      live = wb_we_i && (wb_waddr_i != 5'd0);
      m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
      if (forcing) begin
        if (!(live && wb_waddr_i == mbuf[0][36:32])) begin
          m_we = 1'b1; {m_addr, m_data} = mbuf[0];
          mcu_written++;
        end
        void'(mbuf.pop_front());
        forcing = 0;
      end else if (mbuf.size() != 0) begin
        if (!live) begin
          m_we = 1'b1; {m_addr, m_data} = mbuf.pop_front();
          mcu_written++;
        end else begin
          m_we = 1'b1; m_addr = wb_waddr_i; m_data = wb_wdata_i;
          if (wb_waddr_i == mbuf[0][36:32]) void'(mbuf.pop_front());
          else begin
            deferred++;
            if (deferred >= LIMIT) forcing = 1;
          end
        end
      end else begin
        if (live) begin
          m_we = 1'b1; m_addr = wb_waddr_i; m_data = wb_wdata_i;
        end
        if (mcu_valid_i && mcu_waddr_i != 5'd0) begin
          accepted++;
`ifdef WB_ARB_BYPASS_EN
          if (!live) begin
            m_we = 1'b1; m_addr = mcu_waddr_i; m_data = mcu_wdata_i;
            mcu_written++;
          end else begin
            mbuf.push_back({mcu_waddr_i, mcu_wdata_i}); deferred = 0;
          end
`else
          mbuf.push_back({mcu_waddr_i, mcu_wdata_i}); deferred = 0;
`endif
        end
      end
      if (m_we) model_rf[m_addr] = m_data;
      exp_q.push_back({m_we, m_addr, m_data});
      tick();
      if (exp_ready && mcu_valid_i) set_mcu(1'b0, 5'd0, 32'd0);
      begin
        logic [37:0] e;
        e = exp_q.pop_front();
        checks++;
        if (reg_we_o !== e[37] || (e[37] && (reg_waddr_o !== e[36:32] || reg_wdata_o !== e[31:0]))) begin
          failures++;
          $display("FAIL rand_write c=%0d: got we=%b addr=%0d data=%h, want we=%b addr=%0d data=%h",
                   c, reg_we_o, reg_waddr_o, reg_wdata_o, e[37], e[36:32], e[31:0]);
        end
        if (reg_we_o === 1'b1) dut_rf[reg_waddr_o] = reg_wdata_o;
      end
    end
    idle_inputs();
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (dut_rf[r] !== model_rf[r]) begin
        failures++;
        $display("FAIL rand_regfile x%0d: got %h want %h", r, dut_rf[r], model_rf[r]);
      end
    end
    checks++;
    if (accepted < 50 || mcu_written == 0) begin
      failures++;
      $display("FAIL rand_coverage: accepted=%0d written=%0d, want >=50 and >0", accepted, mcu_written);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_reset_mid_pend();
    test_mcu_latency();
    test_same_cycle();
    test_waw_drop();
    test_starvation();
    test_starve_order();
    test_x0_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
